mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: AW, 64, address width of all address ports.
REQ-002 Parameter: DW, 64, data width of all data ports.
REQ-003 Parameter: STARVE_MAX, 4, consecutive LSU grants allowed while IFU waits before IFU is forced.
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 Port: clk  in  1  sole clock, rising edge.
REQ-006 Port: rst  in  1  asynchronous, active-high reset.
REQ-007 Port: ifu_req / ifu_addr  in  1 / AW  fetch read request and address, held stable until ifu_gnt.
REQ-008 Port: ifu_flush  in  1  discard any in-flight IFU response (redirect on jump/branch).
REQ-009 Port: ifu_gnt / ifu_rvalid / ifu_rdata  out  1 / 1 / DW  grant pulse, response pulse, response data.
REQ-010 Port: lsu_req / lsu_wen / lsu_addr / lsu_wdata / lsu_wlen  in  1 / 1 / AW / DW / 4  load/store request, held stable until lsu_gnt.
REQ-011 Port: lsu_gnt / lsu_rvalid / lsu_rdata  out  1 / 1 / DW  grant pulse, completion pulse (loads and stores), load data.
REQ-012 Port: mem_req / mem_wen / mem_addr / mem_wdata / mem_wlen  out  1 / 1 / AW / DW / 4  shared memory port command.
REQ-013 Port: mem_ready / mem_rvalid / mem_rdata  in  1 / 1 / DW  command accept, response strobe, read data.

Function
REQ-014 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; one transaction outstanding at a time.
REQ-015 IDLE: if ifu_req or lsu_req is 1, the winner SHALL be chosen, its payload latched, owner recorded, and the state SHALL move to ISSUE next cycle; otherwise stay IDLE.
REQ-016 Arbitration: LSU wins when both request, unless streak == STARVE_MAX, in which case IFU wins.
REQ-017 streak SHALL increment (saturating at STARVE_MAX) on an LSU grant with ifu_req=1, and clear to 0 on any IFU grant or on an LSU grant with ifu_req=0.
REQ-018 The winner's gnt SHALL be a registered one-cycle pulse, asserted in the first ISSUE cycle; the loser's gnt SHALL stay 0.
REQ-019 ISSUE: mem_req=1 with latched mem_wen/addr/wdata/wlen (mem_wen=0, mem_wlen=0 for IFU); payload stable until mem_ready=1, then go to WAIT.
REQ-020 mem_req SHALL be 0 in IDLE, WAIT, RESP; mem_* payload outputs SHALL be 0 when mem_req=0.
REQ-021 WAIT: on mem_rvalid=1, mem_rdata SHALL be captured and the state SHALL move to RESP; mem_rvalid in any other state SHALL be ignored.
REQ-022 RESP: owner's rvalid=1 for exactly one cycle with captured data (lsu_rdata undefined-free: 0 for stores); then IDLE.
REQ-023 Minimum occupancy SHALL be 4 cycles per transaction (grant, ISSUE, WAIT, RESP) with 1-cycle mem_ready and mem_rvalid.
REQ-024 ifu_flush=1 in any cycle while owner is IFU in ISSUE/WAIT/RESP SHALL set a drop flag; the memory transaction SHALL still complete, ifu_rvalid SHALL stay 0 for it (including flush in the RESP cycle itself, suppressed combinationally).
REQ-025 ifu_flush SHALL have no effect on LSU transactions or in IDLE; drop flag SHALL clear on return to IDLE.
REQ-026 ifu_rdata/lsu_rdata SHALL be 0 whenever the respective rvalid is 0.

Reset
REQ-027 rst=1 SHALL immediately force state IDLE, streak 0, drop flag 0, owner IFU, all outputs 0, independent of clk.
REQ-028 Reset mid-transaction SHALL abandon it: no gnt/rvalid for it afterward; a late mem_rvalid after reset release SHALL be ignored.
REQ-029 Requests present on the first clock after rst deasserts SHALL be arbitrated normally.

Verification
REQ-030 IFU only, ifu_addr=0x80000000, mem_ready and mem_rvalid 1 cycle later, mem_rdata=0x13 -> ifu_gnt cycle 1, mem_req cycle 1, ifu_rvalid=1 ifu_rdata=0x13 cycle 3.
REQ-031 Both request continuously, LSU loads -> grant order L,L,L,L,I,L,L,L,L,I (STARVE_MAX=4).
REQ-032 LSU store addr=0x100 wdata=0xDEADBEEF wlen=4'hF, mem_ready held 0 for 3 cycles -> mem_req/payload stable 4 cycles, lsu_rvalid=1 once, lsu_rdata=0.
REQ-033 IFU fetch, ifu_flush pulsed in WAIT -> mem transaction completes, ifu_rvalid never 1, next request granted in IDLE.
REQ-034 rst=1 asserted mid-cycle during WAIT, then mem_rvalid=1 after release -> outputs 0 immediately, state IDLE, no rvalid generated.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: IFU/LSU arbiter onto a shared memory port, one transaction outstanding at a time
module mem_arbiter #(
  parameter int AW = 64,
  parameter int DW = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req,
  input  logic [AW-1:0] ifu_addr,
  input  logic          ifu_flush,
  output logic          ifu_gnt,
  output logic          ifu_rvalid,
  output logic [DW-1:0] ifu_rdata,
  input  logic          lsu_req,
  input  logic          lsu_wen,
  input  logic [AW-1:0] lsu_addr,
  input  logic [DW-1:0] lsu_wdata,
  input  logic [3:0]    lsu_wlen,
  output logic          lsu_gnt,
  output logic          lsu_rvalid,
  output logic [DW-1:0] lsu_rdata,
  output logic          mem_req,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic [3:0]    mem_wlen,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          drop_q, drop_d;
  logic          gnt_q, gnt_d;
  logic          wen_q, wen_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [3:0]    wlen_q, wlen_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          lsu_win;
  logic          resp;

  assign lsu_win = lsu_req & (~ifu_req | (streak_q != SMAX));
  assign resp = state_q == RESP;

  // Arbitration, payload capture and transaction sequencing; owner_q=1 means LSU
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    streak_d = streak_q;
    gnt_d    = 1'b0;
    wen_d    = wen_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wlen_d   = wlen_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: if (ifu_req | lsu_req) begin
        state_d  = ISSUE;
        owner_d  = lsu_win;
        gnt_d    = 1'b1;
        wen_d    = lsu_win & lsu_wen;
        addr_d   = lsu_win ? lsu_addr : ifu_addr;
        wdata_d  = lsu_win ? lsu_wdata : '0;
        wlen_d   = lsu_win ? lsu_wlen : '0;
        streak_d = (lsu_win & ifu_req) ? ((streak_q == SMAX) ? streak_q : streak_q + 1'b1) : '0;
      end
      ISSUE: state_d = mem_ready ? WAIT : ISSUE;
      WAIT: if (mem_rvalid) begin
        state_d = RESP;
        rdata_d = wen_q ? '0 : mem_rdata;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A flush during an IFU transaction poisons its response; the flag dies with the transaction
  always_comb begin
    drop_d = (state_q == ISSUE || state_q == WAIT) & (drop_q | (~owner_q & ifu_flush));
  end

  // State and datapath registers; reset abandons any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      streak_q <= '0;
      drop_q   <= 1'b0;
      gnt_q    <= 1'b0;
      wen_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      wlen_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      streak_q <= streak_d;
      drop_q   <= drop_d;
      gnt_q    <= gnt_d;
      wen_q    <= wen_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wlen_q   <= wlen_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ifu_gnt    = gnt_q & ~owner_q;
  assign lsu_gnt    = gnt_q & owner_q;
  assign mem_req    = state_q == ISSUE;
  assign mem_wen    = mem_req & wen_q;
  assign mem_addr   = mem_req ? addr_q : '0;
  assign mem_wdata  = mem_req ? wdata_q : '0;
  assign mem_wlen   = mem_req ? wlen_q : '0;
  assign ifu_rvalid = resp & ~owner_q & ~drop_q & ~ifu_flush;
  assign lsu_rvalid = resp & owner_q;
  assign ifu_rdata  = ifu_rvalid ? rdata_q : '0;
  assign lsu_rdata  = lsu_rvalid ? rdata_q : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory responder
module tb_mem_arbiter;
  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req, ifu_flush;
  logic [AW-1:0] ifu_addr;
  logic          ifu_gnt, ifu_rvalid;
  logic [DW-1:0] ifu_rdata;
  logic          lsu_req, lsu_wen;
  logic [AW-1:0] lsu_addr;
  logic [DW-1:0] lsu_wdata;
  logic [3:0]    lsu_wlen;
  logic          lsu_gnt, lsu_rvalid;
  logic [DW-1:0] lsu_rdata;
  logic          mem_req, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wlen;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  typedef struct packed {logic lsu; logic [DW-1:0] data;} exp_t;
  exp_t sb[$];

  int n_cmp = 0;
  int n_bad = 0;
  int ifu_rv_cnt = 0;
  int lsu_rv_cnt = 0;
  int ready_delay = 0;
  bit rv_en = 1'b1;
  bit late_rv = 1'b0;
  logic any_out;

  assign any_out = |{ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
                     mem_req, mem_wen, mem_addr, mem_wdata, mem_wlen};

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_flush(ifu_flush),
    .ifu_gnt(ifu_gnt), .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_wlen(lsu_wlen),
    .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wlen(mem_wlen),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    return (a == 64'h8000_0000) ? 64'h13 : {a[31:0] ^ 32'hA5A5_A5A5, a[31:0]};
  endfunction

  // Memory responder: accepts after ready_delay cycles, answers one cycle after acceptance
  initial begin : model
    int cnt;
    bit pend;
    logic [DW-1:0] pdata;
    cnt = 0; pend = 1'b0; pdata = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
      if (rst) begin
        pend = 1'b0; cnt = 0;
      end else if (late_rv) begin
        mem_rvalid = 1'b1; mem_rdata = 64'hBAD0_BAD0;
      end else if (pend) begin
        if (rv_en) begin mem_rvalid = 1'b1; mem_rdata = pdata; pend = 1'b0; end
      end else if (mem_req) begin
        if (cnt >= ready_delay) begin
          mem_ready = 1'b1; pend = 1'b1; pdata = mem_fn(mem_addr); cnt = 0;
        end else cnt++;
      end
    end
  end

  // Response monitor: pops the scoreboard on every rvalid and polices zeroed outputs
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (ifu_rvalid || lsu_rvalid) begin
        n_cmp++;
        if (ifu_rvalid && lsu_rvalid) begin
          n_bad++; $display("FAIL dual_rvalid t=%0t ifu=1 lsu=1 required at most one", $time);
        end else if (sb.size() == 0) begin
          n_bad++; $display("FAIL unexpected_rvalid t=%0t ifu=%b lsu=%b required none", $time, ifu_rvalid, lsu_rvalid);
        end else begin
          e = sb.pop_front();
          if ({lsu_rvalid, lsu_rvalid ? lsu_rdata : ifu_rdata} !== {e.lsu, e.data}) begin
            n_bad++;
            $display("FAIL response t=%0t got lsu=%b data=%h required lsu=%b data=%h", $time,
                     lsu_rvalid, lsu_rvalid ? lsu_rdata : ifu_rdata, e.lsu, e.data);
          end
        end
        ifu_rv_cnt += int'(ifu_rvalid);
        lsu_rv_cnt += int'(lsu_rvalid);
      end
      n_cmp++;
      if ((!mem_req && {mem_wen, mem_addr, mem_wdata, mem_wlen} !== '0) ||
          (!ifu_rvalid && ifu_rdata !== '0) || (!lsu_rvalid && lsu_rdata !== '0) || (ifu_gnt && lsu_gnt)) begin
        n_bad++;
        $display("FAIL quiet_outputs t=%0t mem_req=%b addr=%h wdata=%h ifu_rd=%h lsu_rd=%h gnt=%b%b required zeros",
                 $time, mem_req, mem_addr, mem_wdata, ifu_rdata, lsu_rdata, ifu_gnt, lsu_gnt);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog t=%0t bench did not finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ifu_req = 1'b1; ifu_addr = 64'h40; ifu_flush = 1'b0;
    lsu_req = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_wlen = '0;
    #1;
    n_cmp++;
    if (any_out !== 1'b0) begin n_bad++; $display("FAIL reset_t0 outputs=%b required 0", any_out); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (any_out !== 1'b0) begin n_bad++; $display("FAIL reset_held outputs=%b required 0", any_out); end
    tick();
    ifu_req = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_ifu_fetch();
    ifu_addr = 64'h8000_0000; ifu_req = 1'b1;
    sb.push_back({1'b0, 64'h13});
    @(negedge clk);
    n_cmp++;
    if ({ifu_gnt, mem_req} !== 2'b00) begin n_bad++; $display("FAIL fetch_c0 gnt,req=%b required 00", {ifu_gnt, mem_req}); end
    tick();
    ifu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ifu_gnt, lsu_gnt, mem_req, mem_wen, mem_wlen, mem_addr} !== {4'b1010, 4'h0, 64'h8000_0000}) begin
      n_bad++; $display("FAIL fetch_c1 gnt=%b%b req=%b wen=%b wlen=%h addr=%h required 1,0,1,0,0,80000000",
                        ifu_gnt, lsu_gnt, mem_req, mem_wen, mem_wlen, mem_addr);
    end
    @(negedge clk);
    n_cmp++;
    if ({ifu_gnt, mem_req, ifu_rvalid} !== 3'b000) begin n_bad++; $display("FAIL fetch_c2 gnt,req,rv=%b required 000", {ifu_gnt, mem_req, ifu_rvalid}); end
    @(negedge clk);
    n_cmp++;
    if ({ifu_rvalid, ifu_rdata} !== {1'b1, 64'h13}) begin n_bad++; $display("FAIL fetch_c3 rvalid=%b rdata=%h required 1 13", ifu_rvalid, ifu_rdata); end
    tick();
  endtask

  task automatic test_starve();
    string order;
    int k;
    logic g;
    order = "LLLLILLLLI"; k = 0;
    ready_delay = 0;
    ifu_addr = 64'h1000; lsu_addr = 64'h2000; lsu_wen = 1'b0;
    ifu_req = 1'b1; lsu_req = 1'b1;
    for (int c = 0; c < 200 && k < 10; c++) begin
      @(negedge clk);
      if (ifu_gnt || lsu_gnt) begin
        g = lsu_gnt;
        n_cmp++;
        if (g !== (order[k] == "L")) begin
          n_bad++; $display("FAIL grant_order idx=%0d got=%s required=%s", k, g ? "L" : "I", order.substr(k, k));
        end
        sb.push_back({g, mem_fn(g ? lsu_addr : ifu_addr)});
        if (g) lsu_addr = lsu_addr + 64'h8; else ifu_addr = ifu_addr + 64'h8;
        k++;
      end
    end
    n_cmp++;
    if (k != 10) begin n_bad++; $display("FAIL grant_timeout grants=%0d required 10", k); end
    tick();
    ifu_req = 1'b0; lsu_req = 1'b0;
    repeat (6) tick();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL starve_drain pending=%0d required 0", sb.size()); end
  endtask

  task automatic test_store();
    int base;
    base = lsu_rv_cnt;
    ready_delay = 3;
    lsu_req = 1'b1; lsu_wen = 1'b1; lsu_addr = 64'h100; lsu_wdata = 64'hDEAD_BEEF; lsu_wlen = 4'hF;
    sb.push_back({1'b1, 64'h0});
    tick();
    lsu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({lsu_gnt, mem_req, mem_wen, mem_addr, mem_wdata, mem_wlen} !== {i == 0, 1'b1, 1'b1, 64'h100, 64'hDEAD_BEEF, 4'hF}) begin
        n_bad++; $display("FAIL store_issue cyc=%0d gnt=%b req=%b wen=%b addr=%h wdata=%h wlen=%h required gnt=%b 1 1 100 deadbeef f",
                          i, lsu_gnt, mem_req, mem_wen, mem_addr, mem_wdata, mem_wlen, i == 0);
      end
    end
    @(negedge clk);
    n_cmp++;
    if (mem_req !== 1'b0) begin n_bad++; $display("FAIL store_wait mem_req=%b required 0", mem_req); end
    repeat (4) tick();
    n_cmp++;
    if (lsu_rv_cnt - base != 1 || sb.size() != 0) begin
      n_bad++; $display("FAIL store_resp pulses=%0d pending=%0d required 1 0", lsu_rv_cnt - base, sb.size());
    end
    ready_delay = 0; lsu_wen = 1'b0; lsu_wdata = '0; lsu_wlen = '0;
  endtask

  task automatic test_flush();
    int base;
    base = ifu_rv_cnt;
    ifu_req = 1'b1; ifu_addr = 64'h3000;
    tick();
    ifu_req = 1'b0;
    tick();
    ifu_flush = 1'b1;
    tick();
    ifu_flush = 1'b0;
    lsu_req = 1'b1; lsu_addr = 64'h4000; lsu_wen = 1'b0;
    sb.push_back({1'b1, mem_fn(64'h4000)});
    @(negedge clk);
    n_cmp++;
    if (ifu_rvalid !== 1'b0) begin n_bad++; $display("FAIL flush_wait rvalid=%b required 0", ifu_rvalid); end
    @(negedge clk);
    n_cmp++;
    if (lsu_gnt !== 1'b0) begin n_bad++; $display("FAIL flush_idle lsu_gnt=%b required 0", lsu_gnt); end
    @(negedge clk);
    n_cmp++;
    if (lsu_gnt !== 1'b1) begin n_bad++; $display("FAIL flush_next_gnt lsu_gnt=%b required 1", lsu_gnt); end
    tick();
    lsu_req = 1'b0; ifu_flush = 1'b1;
    tick();
    ifu_flush = 1'b0;
    repeat (2) tick();
    ifu_req = 1'b1; ifu_addr = 64'h5000;
    tick();
    ifu_req = 1'b0;
    repeat (2) tick();
    ifu_flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (ifu_rvalid !== 1'b0) begin n_bad++; $display("FAIL flush_resp rvalid=%b required 0", ifu_rvalid); end
    tick();
    ifu_flush = 1'b0;
    ifu_req = 1'b1; ifu_addr = 64'h6000;
    sb.push_back({1'b0, mem_fn(64'h6000)});
    tick();
    ifu_req = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (ifu_rv_cnt - base != 1 || sb.size() != 0) begin
      n_bad++; $display("FAIL flush_recover ifu_pulses=%0d pending=%0d required 1 0", ifu_rv_cnt - base, sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int bi, bl;
    logic seen;
    ready_delay = 100;
    ifu_req = 1'b1; ifu_addr = 64'h7000;
    tick();
    ifu_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({ifu_gnt, mem_req} !== 2'b11) begin n_bad++; $display("FAIL rst_issue_pre gnt,req=%b required 11", {ifu_gnt, mem_req}); end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (any_out !== 1'b0) begin n_bad++; $display("FAIL rst_issue_async outputs=%b required 0", any_out); end
    tick();
    rst = 1'b0; ready_delay = 0; rv_en = 1'b0;
    tick();
    ifu_req = 1'b1; ifu_addr = 64'h7100;
    tick();
    ifu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (any_out !== 1'b0) begin n_bad++; $display("FAIL rst_wait_async outputs=%b required 0", any_out); end
    bi = ifu_rv_cnt; bl = lsu_rv_cnt; seen = 1'b0;
    tick();
    rst = 1'b0; rv_en = 1'b1; late_rv = 1'b1;
    tick();
    late_rv = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | ifu_gnt | lsu_gnt | ifu_rvalid | lsu_rvalid | mem_req;
    end
    n_cmp++;
    if (seen !== 1'b0 || ifu_rv_cnt != bi || lsu_rv_cnt != bl) begin
      n_bad++; $display("FAIL rst_late_rvalid activity=%b required 0", seen);
    end
    tick();
    rst = 1'b1; ifu_req = 1'b1; ifu_addr = 64'h8800;
    sb.push_back({1'b0, mem_fn(64'h8800)});
    tick();
    @(negedge clk);
    n_cmp++;
    if (ifu_gnt !== 1'b0) begin n_bad++; $display("FAIL rst_hold_gnt gnt=%b required 0", ifu_gnt); end
    #2 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ifu_gnt !== 1'b1) begin n_bad++; $display("FAIL rst_release_gnt gnt=%b required 1", ifu_gnt); end
    tick();
    ifu_req = 1'b0;
    repeat (4) tick();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL rst_release_resp pending=%0d required 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_ifu_fetch();
    test_starve();
    test_store();
    test_flush();
    test_reset_mid();
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL final_drain pending=%0d required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
